// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between the scan controller and whatever loads display values
// and drives the 7-segment board (decoder nibble, digit select, anode blanking).
interface display_scan_ctrl_if;
  // load is a one-cycle strobe with no ready: it is always accepted outside
  // reset, and a later load before the frame boundary replaces the earlier one.
  logic        load;
  logic [15:0] value_in;
  logic        lz_blank_en;
  logic [3:0]  nibble_out;
  logic [1:0]  digit_sel;
  logic        blank;
  logic        frame_tick;
  logic        pending;

  modport master (
    output load, value_in, lz_blank_en,
    input  nibble_out, digit_sel, blank, frame_tick, pending
  );

  modport slave (
    input  load, value_in, lz_blank_en,
    output nibble_out, digit_sel, blank, frame_tick, pending
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with frame-synchronous value update,
// anti-ghosting blanking window and optional leading-zero suppression.
module display_scan_ctrl #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic                clk,
  input logic                rst,
  display_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    dsel;
  logic [15:0]   disp;
  logic [15:0]   pend_val;
  logic          pend_q;
  logic          tick_q;
  logic          slot_end;
  logic          wrap;
  logic [3:0]    nib;
  logic          supp;

  assign slot_end = (cnt == LAST);
  assign wrap     = slot_end && (dsel == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      dsel     <= 2'd0;
      disp     <= 16'h0000;
      pend_val <= 16'h0000;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt    <= slot_end ? '0 : cnt + CW'(1);
      tick_q <= wrap;
      if (slot_end)
        dsel <= dsel + 2'd1;
      // The display only moves at the 3->0 wrap so a frame is never torn;
      // a load on that same edge refills pending after the transfer.
      if (wrap && pend_q) begin
        disp   <= pend_val;
        pend_q <= 1'b0;
      end
      if (bus.load) begin
        pend_val <= bus.value_in;
        pend_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    nib = disp[{dsel, 2'b00} +: 4];
  end

  // Digit 0 is never suppressed so an all-zero value still shows one "0".
  always_comb begin
    supp = 1'b0;
    if (bus.lz_blank_en) begin
      case (dsel)
        2'd3:    supp = (disp[15:12] == 4'h0);
        2'd2:    supp = (disp[15:8] == 8'h00);
        2'd1:    supp = (disp[15:4] == 12'h000);
        default: supp = 1'b0;
      endcase
    end
  end

  assign bus.nibble_out = nib;
  assign bus.digit_sel  = dsel;
  assign bus.blank      = rst | (cnt < BLK) | supp;
  assign bus.frame_tick = tick_q;
  assign bus.pending    = pend_q;
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit common-anode 7-segment board.
- Feeds the existing hex-to-segment decoder: drives its w/x/y/z nibble inputs and its 2-bit digit-select input (GTV).
- Holds a 16-bit display value with frame-synchronous (tear-free) update.
- Adds anti-ghosting blanking and optional leading-zero suppression.

Parameters:
- PRESCALE, 50000: clk cycles per digit slot (1 kHz digit rate at 50 MHz); must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with blank forced high; must be < PRESCALE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe; captures value_in into the pending register.
- value_in  input  16  value to display; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- lz_blank_en  input  1  1 = suppress leading zero digits.
- nibble_out  output  4  nibble for the current digit; bit3 = w, bit2 = x, bit1 = y, bit0 = z.
- digit_sel  output  2  current digit index; drives decoder GTV.
- blank  output  1  1 = all anodes must be off (board gates anode enables with it).
- frame_tick  output  1  one-cycle pulse on each 3->0 digit wrap.
- pending  output  1  1 = a loaded value is awaiting the next frame boundary.

Behaviour:
- Reset (async, immediate):
  - slot counter = 0; digit_sel = 0; display register = 16'h0000; pending register = 0.
  - pending = 0; frame_tick = 0; blank = 1; nibble_out = 0.
- Slot counter:
  - Counts 0..PRESCALE-1.
  - On the cycle where it equals PRESCALE-1: next edge sets counter = 0 and digit_sel = digit_sel+1 mod 4.
  - Digit order is 0,1,2,3,0,...
- frame_tick:
  - Registered; high exactly the one cycle after the edge where digit_sel goes 3->0.
  - Period = 4*PRESCALE cycles.
- nibble_out:
  - Combinational from registered state: display[4*digit_sel +: 4].
  - Changes on the same edge as digit_sel.
- blank:
  - Combinational. 1 when rst is high, or counter < BLANK_CYCLES, or the current digit is suppressed.
- Suppression:
  - Only when lz_blank_en = 1.
  - Digit k (k = 3,2,1) is suppressed iff nibbles k..3 of the display register are all zero.
  - Digit 0 is never suppressed, so 0000 shows a single "0".
  - lz_blank_en takes effect immediately.
- Load / shadowing:
  - load = 1 writes value_in into the pending register and sets pending = 1.
  - A second load before the frame boundary overwrites the first (last write wins).
- Frame boundary = the edge where digit_sel goes 3->0. At that edge:
  - If pending = 1: display register <= pending register and pending clears.
  - If load is also high on that same edge: the old pending value transfers to the display, and value_in goes to the pending register with pending = 1.
  - If pending = 0 and no load: display is unchanged.
- Display register never changes mid-frame. This guarantees no torn frames.
- rst asserted mid-slot or mid-frame: all state returns to reset values at once. Any pending value is discarded.
- Scanning restarts at digit 0, counter 0, after rst deasserts. blank stays high for the first BLANK_CYCLES cycles.
- load during rst is ignored.

Test Plan (PRESCALE = 8, BLANK_CYCLES = 2 unless noted):
- Reset/scan:
  - Stimulus: release rst, no load.
  - Required: digit_sel 0,1,2,3,0 changing every 8 cycles; nibble_out = 0.
  - Required: blank high for counter 0-1 and low for 2-7 of each slot; frame_tick pulses every 32 cycles.
- Frame-synchronous load:
  - Stimulus: load 16'hA3C5 during digit 1.
  - Required: pending = 1; nibble_out stays 0 through digit 3.
  - Required: after the wrap, digits 0..3 show 5, C, 3, A and pending = 0.
- Overwrite and simultaneous load:
  - Stimulus: load 16'h1111, then 16'h2222 in the same frame.
  - Required: next frame shows 2222.
  - Stimulus: load 16'h3333 exactly on the wrap edge while 16'h4444 is pending.
  - Required: that frame shows 4444, the following frame shows 3333, pending stays high in between.
- Leading-zero blanking:
  - Stimulus: display 16'h0070 with lz_blank_en = 1.
  - Required: blank = 1 for all of digits 3 and 2; blank follows the counter rule on digits 1 and 0.
  - Stimulus: display 16'h0000.
  - Required: only digit 0 unblanked, showing 0.
  - Stimulus: lz_blank_en = 0.
  - Required: all digits unblanked after the blanking window.
- Reset mid-operation:
  - Stimulus: assert rst at digit 2, counter 5, with pending = 1.
  - Required: same cycle, digit_sel = 0, blank = 1, pending = 0; display = 0000 after release.
- Width/limit check:
  - Stimulus: PRESCALE = 2, BLANK_CYCLES = 1.
  - Required: digit changes every 2 cycles; blank alternates 1,0; no counter overflow.
